// File: rtl/r22sdf_pkg.sv
// r22sdf_pkg: shared types for the R2^2SDF FFT pipeline stages.
package r22sdf_pkg;

    localparam int SDF_WIDTH = 16;

    typedef struct packed {
        logic signed [SDF_WIDTH-1:0] re;
        logic signed [SDF_WIDTH-1:0] im;
    } cplx_t;

    typedef enum logic {
        ST_RUN,
        ST_FLUSH
    } sdf_state_e;

endpackage

// File: rtl/sdf_delay_line.sv
// sdf_delay_line: enable-gated shift register of packed {re,im} samples.
module sdf_delay_line #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               shift_en,
    input  logic [2*WIDTH-1:0] line_in,
    output logic [2*WIDTH-1:0] head
);

    logic [2*WIDTH-1:0] mem_q [DEPTH];
    logic [2*WIDTH-1:0] mem_d [DEPTH];

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            mem_d[i] = mem_q[i];
        end
        if (shift_en) begin
            mem_d[0] = line_in;
            for (int i = 1; i < DEPTH; i++) begin
                mem_d[i] = mem_q[i-1];
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    assign head = mem_q[DEPTH-1];

endmodule

// File: rtl/sdf_bf_stage_ctrl.sv
// sdf_bf_stage_ctrl: sequencer for one radix-2 SDF butterfly stage.
// Owns the feedback delay line, frame counter and flush-drain FSM.
module sdf_bf_stage_ctrl
    import r22sdf_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                          clock,
    input  logic                          reset_n,
    input  logic                          di_en,
    input  logic [WIDTH-1:0]              di_re,
    input  logic [WIDTH-1:0]              di_im,
    output logic                          di_ready,
    input  logic                          flush,
    output logic [WIDTH-1:0]              bf_x0_re,
    output logic [WIDTH-1:0]              bf_x0_im,
    output logic [WIDTH-1:0]              bf_x1_re,
    output logic [WIDTH-1:0]              bf_x1_im,
    input  logic [WIDTH-1:0]              bf_y0_re,
    input  logic [WIDTH-1:0]              bf_y0_im,
    input  logic [WIDTH-1:0]              bf_y1_re,
    input  logic [WIDTH-1:0]              bf_y1_im,
    output logic                          do_en,
    output logic [WIDTH-1:0]              do_re,
    output logic [WIDTH-1:0]              do_im,
    output logic [$clog2(2*DEPTH)-1:0]    do_idx
);

    localparam int CW = $clog2(2*DEPTH);
    localparam logic [CW-1:0] M_C     = CW'(DEPTH);
    localparam logic [CW-1:0] LAST_C  = CW'(2*DEPTH-1);
    localparam logic [CW-1:0] FLAST_C = CW'(DEPTH-1);

    sdf_state_e state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic buf_valid_q, buf_valid_d;
    logic flush_pend_q, flush_pend_d;
    logic do_en_q, do_en_d;
    logic [WIDTH-1:0] do_re_q, do_re_d;
    logic [WIDTH-1:0] do_im_q, do_im_d;
    logic [CW-1:0] do_idx_q, do_idx_d;

    logic shift_en;
    logic [2*WIDTH-1:0] line_in;
    logic [2*WIDTH-1:0] head;
    logic [WIDTH-1:0] head_re, head_im;
    logic accept, phase_b;

    sdf_delay_line #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_line (
        .clock    (clock),
        .reset_n  (reset_n),
        .shift_en (shift_en),
        .line_in  (line_in),
        .head     (head)
    );

    assign head_re  = head[2*WIDTH-1:WIDTH];
    assign head_im  = head[WIDTH-1:0];
    assign di_ready = (state_q == ST_RUN);
    assign accept   = di_en && di_ready;
    assign phase_b  = cnt_q[CW-1];

    assign bf_x0_re = head_re;
    assign bf_x0_im = head_im;
    assign bf_x1_re = di_re;
    assign bf_x1_im = di_im;

    // Output index is cnt+M in phase A / flush and cnt-M in phase B: both are cnt ^ M.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        buf_valid_d  = buf_valid_q;
        flush_pend_d = flush_pend_q;
        do_en_d      = 1'b0;
        do_re_d      = do_re_q;
        do_im_d      = do_im_q;
        do_idx_d     = do_idx_q;
        shift_en     = 1'b0;
        line_in      = '0;
        unique case (state_q)
            ST_RUN: begin
                flush_pend_d = flush_pend_q | flush;
                if (accept) begin
                    shift_en = 1'b1;
                    cnt_d    = cnt_q + 1'b1;
                    if (phase_b) begin
                        line_in  = {bf_y1_re, bf_y1_im};
                        do_en_d  = 1'b1;
                        do_re_d  = bf_y0_re;
                        do_im_d  = bf_y0_im;
                        do_idx_d = cnt_q ^ M_C;
                        if (cnt_q == LAST_C) begin
                            buf_valid_d = 1'b1;
                        end
                    end else begin
                        line_in = {di_re, di_im};
                        if (buf_valid_q) begin
                            do_en_d  = 1'b1;
                            do_re_d  = head_re;
                            do_im_d  = head_im;
                            do_idx_d = cnt_q ^ M_C;
                        end
                    end
                end else if (flush_pend_q && cnt_q == '0) begin
                    flush_pend_d = 1'b0;
                    if (buf_valid_q) begin
                        state_d = ST_FLUSH;
                    end
                end
            end
            ST_FLUSH: begin
                shift_en     = 1'b1;
                flush_pend_d = 1'b0;
                do_en_d      = 1'b1;
                do_re_d      = head_re;
                do_im_d      = head_im;
                do_idx_d     = cnt_q ^ M_C;
                if (cnt_q == FLAST_C) begin
                    state_d     = ST_RUN;
                    cnt_d       = '0;
                    buf_valid_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_RUN;
            cnt_q        <= '0;
            buf_valid_q  <= 1'b0;
            flush_pend_q <= 1'b0;
            do_en_q      <= 1'b0;
            do_re_q      <= '0;
            do_im_q      <= '0;
            do_idx_q     <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            buf_valid_q  <= buf_valid_d;
            flush_pend_q <= flush_pend_d;
            do_en_q      <= do_en_d;
            do_re_q      <= do_re_d;
            do_im_q      <= do_im_d;
            do_idx_q     <= do_idx_d;
        end
    end

    assign do_en  = do_en_q;
    assign do_re  = do_re_q;
    assign do_im  = do_im_q;
    assign do_idx = do_idx_q;

endmodule

// File: tb/tb_sdf_bf_stage_ctrl.sv
// tb_sdf_bf_stage_ctrl: directed vector bench for the SDF stage sequencer.
// A combinational (x0+x1)/2, (x0-x1)/2 butterfly closes the loop.
module tb_sdf_bf_stage_ctrl;

    typedef struct {
        logic               en;
        logic               fl;
        logic signed [15:0] re;
        logic               xen;
        logic signed [15:0] xre;
        logic [1:0]         xidx;
        logic               xrdy;
    } vec_t;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    logic di_en = 1'b0;
    logic signed [15:0] di_re = '0;
    logic signed [15:0] di_im = '0;
    logic di_ready;
    logic flush = 1'b0;
    logic signed [15:0] bf_x0_re, bf_x0_im, bf_x1_re, bf_x1_im;
    logic signed [15:0] bf_y0_re, bf_y0_im, bf_y1_re, bf_y1_im;
    logic do_en;
    logic signed [15:0] do_re, do_im;
    logic [1:0] do_idx;

    logic signed [16:0] s_re, d_re, s_im, d_im;

    int n_tests = 0;
    int n_fail = 0;
    vec_t tbl[$];

    always #5 clock = ~clock;

    sdf_bf_stage_ctrl #(
        .WIDTH (16),
        .DEPTH (2)
    ) dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .di_en    (di_en),
        .di_re    (di_re),
        .di_im    (di_im),
        .di_ready (di_ready),
        .flush    (flush),
        .bf_x0_re (bf_x0_re),
        .bf_x0_im (bf_x0_im),
        .bf_x1_re (bf_x1_re),
        .bf_x1_im (bf_x1_im),
        .bf_y0_re (bf_y0_re),
        .bf_y0_im (bf_y0_im),
        .bf_y1_re (bf_y1_re),
        .bf_y1_im (bf_y1_im),
        .do_en    (do_en),
        .do_re    (do_re),
        .do_im    (do_im),
        .do_idx   (do_idx)
    );

    assign s_re = {bf_x0_re[15], bf_x0_re} + {bf_x1_re[15], bf_x1_re};
    assign d_re = {bf_x0_re[15], bf_x0_re} - {bf_x1_re[15], bf_x1_re};
    assign s_im = {bf_x0_im[15], bf_x0_im} + {bf_x1_im[15], bf_x1_im};
    assign d_im = {bf_x0_im[15], bf_x0_im} - {bf_x1_im[15], bf_x1_im};
    assign bf_y0_re = s_re[16:1];
    assign bf_y1_re = d_re[16:1];
    assign bf_y0_im = s_im[16:1];
    assign bf_y1_im = d_im[16:1];

    task automatic chk(input string name, input logic [15:0] act,
                       input logic [15:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d",
                     name, $signed(act), $signed(exp));
        end
    endtask

    function automatic vec_t V(input logic en, input logic fl,
                               input logic signed [15:0] re,
                               input logic xen,
                               input logic signed [15:0] xre,
                               input logic [1:0] xidx,
                               input logic xrdy);
        vec_t v;
        v.en = en; v.fl = fl; v.re = re;
        v.xen = xen; v.xre = xre; v.xidx = xidx; v.xrdy = xrdy;
        return v;
    endfunction

    // Inputs are applied just after a rising edge; outputs checked 1 time unit after the next.
    task automatic cyc(input string tag, input vec_t v);
        di_en = v.en;
        flush = v.fl;
        di_re = v.re;
        #1;
        chk({tag, " rdy"}, {15'd0, di_ready}, {15'd0, v.xrdy});
        @(posedge clock);
        #1;
        di_en = 1'b0;
        flush = 1'b0;
        chk({tag, " en"}, {15'd0, do_en}, {15'd0, v.xen});
        if (v.xen) begin
            chk({tag, " re"}, do_re, v.xre);
            chk({tag, " im"}, do_im, 16'd0);
            chk({tag, " idx"}, {14'd0, do_idx}, {14'd0, v.xidx});
        end
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        di_en = 1'b0;
        flush = 1'b0;
        @(posedge clock);
        #2;
        reset_n = 1'b1;
        @(posedge clock);
        #1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, " do_en"}, {15'd0, do_en}, 16'd0);
        chk({tag, " do_re"}, do_re, 16'd0);
        chk({tag, " do_im"}, do_im, 16'd0);
        chk({tag, " do_idx"}, {14'd0, do_idx}, 16'd0);
        chk({tag, " rdy"}, {15'd0, di_ready}, 16'd1);
    endtask

    initial begin
        // frame 1 then flush
        tbl.push_back(V(1, 0,  4, 0,  0, 0, 1));
        tbl.push_back(V(1, 0,  8, 0,  0, 0, 1));
        tbl.push_back(V(1, 0, 12, 1,  8, 0, 1));
        tbl.push_back(V(1, 0, 16, 1, 12, 1, 1));
        tbl.push_back(V(0, 1,  0, 0,  0, 0, 1));
        tbl.push_back(V(0, 0,  0, 0,  0, 0, 1));
        tbl.push_back(V(0, 0,  0, 1, -4, 2, 0));
        tbl.push_back(V(0, 0,  0, 1, -4, 3, 0));
        tbl.push_back(V(0, 0,  0, 0,  0, 0, 1));
        // two back-to-back frames, buffer starts empty after flush
        tbl.push_back(V(1, 0,  4, 0,  0, 0, 1));
        tbl.push_back(V(1, 0,  8, 0,  0, 0, 1));
        tbl.push_back(V(1, 0, 12, 1,  8, 0, 1));
        tbl.push_back(V(1, 0, 16, 1, 12, 1, 1));
        tbl.push_back(V(1, 0,  2, 1, -4, 2, 1));
        tbl.push_back(V(1, 0,  2, 1, -4, 3, 1));
        tbl.push_back(V(1, 0,  2, 1,  2, 0, 1));
        tbl.push_back(V(1, 0,  2, 1,  2, 1, 1));
        // flush at cnt=1 held until wrap; di_en during drain ignored
        tbl.push_back(V(1, 0,  4, 1,  0, 2, 1));
        tbl.push_back(V(1, 1,  8, 1,  0, 3, 1));
        tbl.push_back(V(1, 0, 12, 1,  8, 0, 1));
        tbl.push_back(V(1, 0, 16, 1, 12, 1, 1));
        tbl.push_back(V(0, 0,  0, 0,  0, 0, 1));
        tbl.push_back(V(1, 0, 99, 1, -4, 2, 0));
        tbl.push_back(V(1, 0, 99, 1, -4, 3, 0));
        tbl.push_back(V(0, 0,  0, 0,  0, 0, 1));
        // flush with empty buffer does nothing
        tbl.push_back(V(0, 1,  0, 0,  0, 0, 1));
        tbl.push_back(V(0, 0,  0, 0,  0, 0, 1));
        tbl.push_back(V(0, 0,  0, 0,  0, 0, 1));
        // flush with di_en at cnt=0: sample taken, drain at next boundary
        tbl.push_back(V(1, 1,  4, 0,  0, 0, 1));
        tbl.push_back(V(1, 0,  8, 0,  0, 0, 1));
        tbl.push_back(V(1, 0, 12, 1,  8, 0, 1));
        tbl.push_back(V(1, 0, 16, 1, 12, 1, 1));
        tbl.push_back(V(0, 0,  0, 0,  0, 0, 1));
        tbl.push_back(V(0, 0,  0, 1, -4, 2, 0));
        tbl.push_back(V(0, 0,  0, 1, -4, 3, 0));
        tbl.push_back(V(0, 0,  0, 0,  0, 0, 1));

        #3;
        chk_reset_vals("in_reset");
        do_reset();
        chk_reset_vals("post_reset");

        for (int i = 0; i < tbl.size(); i++) begin
            cyc($sformatf("v%0d", i), tbl[i]);
        end

        // frame with a 3-cycle input gap after sample 2
        do_reset();
        cyc("gap0", V(1, 0,  4, 0,  0, 0, 1));
        cyc("gap1", V(1, 0,  8, 0,  0, 0, 1));
        cyc("gap2", V(0, 0, 55, 0,  0, 0, 1));
        cyc("gap3", V(0, 0, 55, 0,  0, 0, 1));
        cyc("gap4", V(0, 0, 55, 0,  0, 0, 1));
        cyc("gap5", V(1, 0, 12, 1,  8, 0, 1));
        cyc("gap6", V(0, 0,  0, 0,  0, 0, 1));
        cyc("gap7", V(1, 0, 16, 1, 12, 1, 1));

        // asynchronous reset in phase B aborts the frame
        do_reset();
        cyc("rst0", V(1, 0,  4, 0,  0, 0, 1));
        cyc("rst1", V(1, 0,  8, 0,  0, 0, 1));
        cyc("rst2", V(1, 0, 12, 1,  8, 0, 1));
        di_en = 1'b1;
        di_re = 16'sd16;
        #2;
        reset_n = 1'b0;
        #1;
        di_en = 1'b0;
        chk_reset_vals("async_rst");
        @(posedge clock);
        #1;
        chk_reset_vals("held_rst");
        reset_n = 1'b1;
        #1;
        cyc("rst3", V(1, 0,  4, 0,  0, 0, 1));
        cyc("rst4", V(1, 0,  8, 0,  0, 0, 1));
        cyc("rst5", V(1, 0, 12, 1,  8, 0, 1));
        cyc("rst6", V(1, 0, 16, 1, 12, 1, 1));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
